// File: rtl/perf_pkg.sv
// Shared types and constants for the performance monitor block.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter slot 0 is always the free-running cycle counter.
  localparam int unsigned IDX_CYCLE = 0;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single wrapping counter with enable, synchronous clear and a sticky wrap flag.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Clear beats enable; the flag latches on the all-ones to zero step.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == '1) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Cycle/event performance monitor: run/pause/limit FSM, live counters,
// snapshot shadows and a one-cycle-latency shadow read port.
module perf_monitor
  import perf_pkg::*;
#(
  parameter  int unsigned NUM_EVT = 4,
  parameter  int unsigned CNT_W   = 32,
  parameter  int unsigned LIMIT_W = 32,
  localparam int unsigned SEL_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [LIMIT_W-1:0] limit_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic               rd_req_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               done_o,
  output logic               run_o
);

  localparam int unsigned NUM_CNT = NUM_EVT + 1;
  localparam int unsigned CMP_W   = max_w(CNT_W, LIMIT_W);

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   done_q, done_d;

  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_all;
  logic [NUM_CNT-1:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [NUM_CNT-1:0]            cnt_en;
  logic [NUM_CNT-1:0]            ovf_all;

  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             counting;
  logic [CNT_W-1:0] cyc_inc;
  logic             limit_hit;

  assign counting = (state_q == ST_RUN);
  assign cyc_inc  = cnt_all[IDX_CYCLE] + CNT_W'(1);
  // Limit compares against the value the cycle counter is about to take.
  assign limit_hit = (limit_i != '0) && (CMP_W'(cyc_inc) == CMP_W'(limit_i));

  // Slot 0 counts every RUN cycle; slot k counts RUN cycles with evt_i[k-1].
  assign cnt_en = {evt_i, 1'b1} & {NUM_CNT{counting}};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (cnt_en[g]),
      .cnt_o (cnt_all[g]),
      .ovf_o (ovf_all[g])
    );
  end

  // FSM state and registered status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  // Next state; clear forces IDLE from anywhere, start_i is ignored in DONE.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN: begin
          if (limit_hit) begin
            state_d = ST_DONE;
          end else if (!start_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status flags follow the state being entered so they align with state_q.
  always_comb begin
    run_d  = 1'b0;
    done_d = 1'b0;
    if (state_d == ST_RUN) begin
      run_d = 1'b1;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  // Snapshot copies the registered (pre-increment) counter values.
  always_comb begin
    shadow_d = shadow_q;
    if (clear_i) begin
      shadow_d = '0;
    end else if (snap_i) begin
      shadow_d = cnt_all;
    end
  end

  // Reads see the shadow as it was before any same-cycle snap or clear.
  always_comb begin
    rd_valid_d = rd_req_i;
    rd_data_d  = rd_data_q;
    if (rd_req_i) begin
      if (rd_sel_i <= SEL_W'(NUM_EVT)) begin
        rd_data_d = shadow_q[rd_sel_i];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ovf_o      = ovf_all;
  assign done_o     = done_q;
  assign run_o      = run_q;

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter NUM_EVT, 4, number of event channels.
REQ-002 Parameter CNT_W, 32, width of every counter and of rd_data_o.
REQ-003 Parameter LIMIT_W, 32, width of limit_i.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  run enable; 1 = count, 0 = pause.
REQ-007 evt_i  in  NUM_EVT  per-cycle event strobes (e.g. stall, flush).
REQ-008 limit_i  in  LIMIT_W  cycle limit; 0 = unlimited.
REQ-009 clear_i  in  1  zero all counters, overflow flags and shadows; leave DONE.
REQ-010 snap_i  in  1  copy all live counters into shadow registers.
REQ-011 rd_req_i  in  1  read request.
REQ-012 rd_sel_i  in  $clog2(NUM_EVT+1)  read index; 0 = cycle counter, k = event k-1.
REQ-013 rd_data_o  out  CNT_W  selected shadow value.
REQ-014 rd_valid_o  out  1  rd_data_o valid.
REQ-015 ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter.
REQ-016 done_o  out  1  limit reached; asserted while in DONE.
REQ-017 run_o  out  1  asserted while in RUN.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN when start_i=1; RUN->IDLE when start_i=0.
REQ-019 In RUN, cycle counter increments by 1 each cycle; event counter k increments in each cycle where evt_i[k]=1.
REQ-020 In IDLE and DONE, all counters hold their values.
REQ-021 RUN->DONE in the cycle where the cycle counter is updated to equal limit_i (limit_i != 0); that final increment is taken; done_o=1 from the next cycle.
REQ-022 DONE->IDLE only on clear_i; start_i is ignored in DONE.
REQ-023 Counters wrap modulo 2^CNT_W; on wrap, corresponding ovf_o bit sets and stays set until clear_i or rst_i.
REQ-024 clear_i has priority over counting, snap_i and the FSM; counters, ovf_o and shadows become 0 and the state becomes IDLE, even if evt_i or start_i is 1 in the same cycle.
REQ-025 snap_i in the same cycle as an increment captures the pre-increment value.
REQ-026 rd_req_i=1 in cycle n gives rd_valid_o=1 and rd_data_o=shadow[rd_sel_i] in cycle n+1; otherwise rd_valid_o=0 and rd_data_o holds.
REQ-027 rd_sel_i > NUM_EVT returns rd_data_o=0 with rd_valid_o=1.
REQ-028 A read and a snap in the same cycle return the pre-snap shadow value.

Reset
REQ-029 rst_i=1: state IDLE; all counters, shadows and ovf_o are 0; rd_data_o=0; rd_valid_o=0; done_o=0; run_o=0 in the following cycle.
REQ-030 rst_i takes priority over every other input, including mid-RUN and in DONE.

Structure
REQ-031 Package perf_pkg holds the state enum and the constant IDX_CYCLE=0.
REQ-032 Sub-module perf_counter (enable, clear, wrap, sticky overflow, CNT_W parameter) is instantiated NUM_EVT+1 times.

Verification
REQ-033 NUM_EVT=2, CNT_W=8: reset, start_i=1, limit_i=30, evt_i=0 -> done_o=1 after 30 RUN cycles; snap, read sel 0 -> 30; counters stay frozen.
REQ-034 evt_i[0]=1 for 3 cycles, evt_i[1]=1 for 1 cycle, then snap -> read sel 1 = 3, sel 2 = 1, each valid one cycle after rd_req_i.
REQ-035 limit_i=0, evt_i[0] held for 256 RUN cycles -> counter 1 = 0, ovf_o[1]=1, ovf_o[0]=1, remaining sticky.
REQ-036 clear_i with evt_i=2'b11 and start_i=1 in the same cycle -> all counters 0, ovf_o=0, state IDLE.
REQ-037 start_i dropped for 5 cycles during a 20-cycle window -> cycle count 15; event pulses during the pause are not counted.
REQ-038 rst_i asserted mid-RUN with counts non-zero -> all outputs 0 and state IDLE in the next cycle; read sel 3 -> 0.
